// File: rtl/iob_axistream_out_arb.sv
// Packet-atomic round-robin arbiter feeding the AXI-stream output FIFO write port.
// One requester owns the port from grant until its tlast byte is written, so
// packets from different producers never interleave in the FIFO.
module iob_axistream_out_arb #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [8*N_REQ-1:0]   s_tdata,
    input  logic [N_REQ-1:0]     s_tvalid,
    input  logic [N_REQ-1:0]     s_tlast,
    output logic [N_REQ-1:0]     s_tready,
    input  logic [N_REQ-1:0]     req_en,
    output logic                 fifo_w_en,
    output logic [8:0]           fifo_w_data,
    input  logic                 fifo_w_full,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 pkt_done,
    output logic [CNT_W-1:0]     pkt_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_pkt_done;
    logic [CNT_W-1:0]   r_pkt_cnt;

    state_t             w_state_next;
    logic [N_REQ-1:0]   w_grant_next;
    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   w_ptr_next;
    logic               w_done_next;
    logic [CNT_W-1:0]   w_cnt_next;

    logic [N_REQ-1:0]   w_cand;
    logic [IDX_W:0]     w_sum;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic               w_own_valid;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic               w_write_last;

    // The owner's byte lane is selected by the stored index; in IDLE the
    // write strobe is gated off so the stale lane is harmless.
    assign w_cand       = s_tvalid & req_en;
    assign w_own_valid  = s_tvalid[r_owner];
    assign w_own_last   = s_tlast[r_owner];
    assign w_own_data   = s_tdata[{r_owner, 3'b000} +: 8];
    assign fifo_w_en    = (r_state == OWN) & w_own_valid & ~fifo_w_full;
    assign w_write_last = fifo_w_en & w_own_last;
    assign fifo_w_data  = {w_own_last, w_own_data};
    assign s_tready     = ((r_state == OWN) && !fifo_w_full) ? r_grant : '0;
    assign grant        = r_grant;
    assign busy         = |r_grant;
    assign pkt_done     = r_pkt_done;
    assign pkt_cnt      = r_pkt_cnt;

    // Round-robin search: first eligible requester at or after ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && w_cand[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: grant from IDLE, release and advance ptr after tlast.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_done_next  = 1'b0;
        w_cnt_next   = r_pkt_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = OWN;
                    w_grant_next = N_REQ'(1) << w_sel;
                    w_owner_next = w_sel;
                end
            end
            OWN: begin
                if (w_write_last) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + IDX_W'(1);
                    w_done_next  = 1'b1;
                    w_cnt_next   = r_pkt_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset clears any packet in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_pkt_done <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_owner    <= w_owner_next;
            r_ptr      <= w_ptr_next;
            r_pkt_done <= w_done_next;
            r_pkt_cnt  <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// Testbench for iob_axistream_out_arb: directed scenarios plus a randomized run
// compared against a packet-level model of the arbitration rules.
module tb_iob_axistream_out_arb;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [8*N-1:0]  s_tdata = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    req_en = '1;
    logic            fifo_w_full = 1'b0;
    logic [N-1:0]    s_tready, s_tready4;
    logic            fifo_w_en, fifo_w_en4;
    logic [8:0]      fifo_w_data, fifo_w_data4;
    logic [N-1:0]    grant, grant4;
    logic            busy, busy4;
    logic            pkt_done, pkt_done4;
    logic [15:0]     pkt_cnt;
    logic [3:0]      pkt_cnt4;

    int checks = 0;
    int failures = 0;

    iob_axistream_out_arb #(.N_REQ(N), .CNT_W(16)) dut (
        .clk(clk), .arst(arst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .req_en(req_en),
        .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data), .fifo_w_full(fifo_w_full),
        .grant(grant), .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
    );

    iob_axistream_out_arb #(.N_REQ(N), .CNT_W(4)) dut4 (
        .clk(clk), .arst(arst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready4), .req_en(req_en),
        .fifo_w_en(fifo_w_en4), .fifo_w_data(fifo_w_data4), .fifo_w_full(fifo_w_full),
        .grant(grant4), .busy(busy4), .pkt_done(pkt_done4), .pkt_cnt(pkt_cnt4)
    );

    always #5 clk = ~clk;

    // Packet-level reference model: owner -1 means nobody holds the port.
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_done = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_step();
        m_done = 1'b0;
        if (m_owner < 0) begin
            for (int off = 0; off < N; off++) begin
                int i = (m_ptr + off) % N;
                if (s_tvalid[i] && req_en[i]) begin
                    m_owner = i;
                    break;
                end
            end
        end else if (s_tvalid[m_owner] && !fifo_w_full && s_tlast[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt++;
            m_done  = 1'b1;
        end
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        return (m_owner >= 0 && !fifo_w_full) ? exp_grant() : '0;
    endfunction

    function automatic logic exp_wen();
        return (m_owner >= 0) && s_tvalid[m_owner] && !fifo_w_full;
    endfunction

    function automatic logic [8:0] exp_wdata();
        if (m_owner < 0) return 9'h0;
        return {s_tlast[m_owner], s_tdata[8*m_owner +: 8]};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
        s_tvalid[i]       = v;
        s_tlast[i]        = l;
        s_tdata[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        arst        = 1'b1;
        s_tvalid    = '0;
        s_tlast     = '0;
        s_tdata     = '0;
        req_en      = '1;
        fifo_w_full = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst     = 1'b1;
        s_tvalid = '1;
        model_reset();
        @(negedge clk);
        #1;
        if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (s_tready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0000", s_tready); end
        checks++;
        if (fifo_w_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen: got %b want 0", fifo_w_en); end
        checks++;
        if (pkt_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", pkt_done); end
        checks++;
        if (pkt_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d want 0", pkt_cnt); end
        checks++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h11);
        #1;
        if (grant !== 4'b0000 || s_tready !== 4'b0000) begin failures++; $display("[TB] FAIL single_idle: grant %b ready %b want 0000/0000", grant, s_tready); end
        checks++;
        tick();
        #1;
        if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL single_grant: got %b want 0001", grant); end
        checks++;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== 9'h011) begin failures++; $display("[TB] FAIL single_b0: wen %b data %h want 1/011", fifo_w_en, fifo_w_data); end
        checks++;
        tick();
        set_req(0, 1'b1, 1'b0, 8'h22);
        #1;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== 9'h022) begin failures++; $display("[TB] FAIL single_b1: wen %b data %h want 1/022", fifo_w_en, fifo_w_data); end
        checks++;
        tick();
        set_req(0, 1'b1, 1'b1, 8'h33);
        #1;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== 9'h133) begin failures++; $display("[TB] FAIL single_b2: wen %b data %h want 1/133", fifo_w_en, fifo_w_data); end
        checks++;
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00);
        #1;
        if (pkt_done !== 1'b1 || pkt_cnt !== 16'd1 || grant !== 4'b0000) begin failures++; $display("[TB] FAIL single_done: done %b cnt %0d grant %b want 1/1/0000", pkt_done, pkt_cnt, grant); end
        checks++;
        tick();
        #1;
        if (pkt_done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_pulse: got %b want 0", pkt_done); end
        checks++;
        set_req(0, 1'b1, 1'b1, 8'hA0);
        set_req(1, 1'b1, 1'b1, 8'hB1);
        tick();
        #1;
        if (grant !== 4'b0010 || fifo_w_data !== 9'h1B1) begin failures++; $display("[TB] FAIL single_ptr: grant %b data %h want 0010/1b1", grant, fifo_w_data); end
        checks++;
        tick();
        s_tvalid = '0;
        #1;
        if (pkt_cnt !== 16'd2) begin failures++; $display("[TB] FAIL single_cnt2: got %0d want 2", pkt_cnt); end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [7:0] b [N][2];
        int pos [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            b[i][0] = 8'($urandom);
            b[i][1] = 8'($urandom);
        end
        for (int c = 0; c < 15; c++) begin
            int phase = c % 3;
            int idx = (c / 3) % N;
            logic [N-1:0] eg;
            logic [8:0] ew;
            for (int i = 0; i < N; i++) set_req(i, 1'b1, pos[i] == 1, b[i][pos[i]]);
            eg = (phase == 0) ? '0 : (N'(1) << idx);
            ew = (phase == 0) ? 9'h0 : {phase == 2, b[idx][phase-1]};
            #1;
            if (grant !== eg) begin failures++; $display("[TB] FAIL rr_grant c%0d: got %b want %b", c, grant, eg); end
            checks++;
            if (phase != 0) begin
                if (fifo_w_en !== 1'b1 || fifo_w_data !== ew) begin failures++; $display("[TB] FAIL rr_data c%0d: wen %b data %h want 1/%h", c, fifo_w_en, fifo_w_data, ew); end
            end else begin
                if (fifo_w_en !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle c%0d: wen %b want 0", c, fifo_w_en); end
            end
            checks++;
            tick();
            if (phase != 0) begin
                pos[idx]++;
                if (pos[idx] == 2) begin
                    pos[idx] = 0;
                    b[idx][0] = 8'($urandom);
                    b[idx][1] = 8'($urandom);
                end
            end
        end
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic test_full_stall();
        logic [7:0] a;
        int writes = 0;
        do_reset();
        a = 8'($urandom);
        set_req(2, 1'b1, 1'b0, a);
        tick();
        #1;
        if (grant !== 4'b0100 || fifo_w_en !== 1'b1 || fifo_w_data !== {1'b0, a}) begin failures++; $display("[TB] FAIL full_first: grant %b wen %b data %h want 0100/1/%h", grant, fifo_w_en, fifo_w_data, {1'b0, a}); end
        checks++;
        tick();
        for (int c = 0; c < 3; c++) begin
            fifo_w_full = 1'b1;
            set_req(2, 1'b1, 1'b1, 8'h5A);
            for (int j = 0; j < N; j++) begin
                if (j != 2) set_req(j, 1'($urandom), 1'($urandom), 8'($urandom));
            end
            #1;
            if (fifo_w_en && fifo_w_data === 9'h15A) writes++;
            if (fifo_w_en !== 1'b0 || s_tready !== 4'b0000) begin failures++; $display("[TB] FAIL full_stall c%0d: wen %b ready %b want 0/0000", c, fifo_w_en, s_tready); end
            checks++;
            if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL full_hold c%0d: grant %b want 0100", c, grant); end
            checks++;
            tick();
        end
        fifo_w_full = 1'b0;
        #1;
        if (fifo_w_en && fifo_w_data === 9'h15A) writes++;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== 9'h15A || s_tready !== 4'b0100) begin failures++; $display("[TB] FAIL full_release: wen %b data %h ready %b want 1/15a/0100", fifo_w_en, fifo_w_data, s_tready); end
        checks++;
        tick();
        s_tvalid = '0;
        s_tlast  = '0;
        #1;
        if (fifo_w_en && fifo_w_data === 9'h15A) writes++;
        if (grant !== 4'b0000 || pkt_done !== 1'b1) begin failures++; $display("[TB] FAIL full_end: grant %b done %b want 0000/1", grant, pkt_done); end
        checks++;
        if (writes != 1) begin failures++; $display("[TB] FAIL full_once: writes %0d want 1", writes); end
        checks++;
        tick();
    endtask

    task automatic test_mask();
        logic [7:0] d0, d1;
        do_reset();
        set_req(1, 1'b1, 1'b1, 8'($urandom));
        tick();
        tick();
        s_tvalid = '0;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        req_en = 4'b1011;
        set_req(0, 1'b1, 1'b0, 8'($urandom));
        set_req(2, 1'b1, 1'b0, 8'($urandom));
        set_req(3, 1'b1, 1'b0, d0);
        tick();
        #1;
        if (grant !== 4'b1000 || fifo_w_data !== {1'b0, d0}) begin failures++; $display("[TB] FAIL mask_grant: grant %b data %h want 1000/%h", grant, fifo_w_data, {1'b0, d0}); end
        checks++;
        tick();
        req_en[3] = 1'b0;
        set_req(3, 1'b1, 1'b1, d1);
        #1;
        if (grant !== 4'b1000 || fifo_w_en !== 1'b1 || fifo_w_data !== {1'b1, d1}) begin failures++; $display("[TB] FAIL mask_keep: grant %b wen %b data %h want 1000/1/%h", grant, fifo_w_en, fifo_w_data, {1'b1, d1}); end
        checks++;
        tick();
        s_tvalid = '0;
        s_tlast  = '0;
        #1;
        if (pkt_done !== 1'b1 || grant !== 4'b0000) begin failures++; $display("[TB] FAIL mask_done: done %b grant %b want 1/0000", pkt_done, grant); end
        checks++;
        req_en = '1;
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        do_reset();
        set_req(0, 1'b1, 1'b1, 8'($urandom));
        tick();
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'($urandom));
        #1;
        if (pkt_cnt !== 16'd1) begin failures++; $display("[TB] FAIL arst_pre_cnt: got %0d want 1", pkt_cnt); end
        checks++;
        tick();
        #1;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL arst_pre_grant: got %b want 0010", grant); end
        checks++;
        tick();
        set_req(1, 1'b1, 1'b0, 8'($urandom));
        #1;
        arst = 1'b1;
        model_reset();
        #1;
        if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL arst_grant: grant %b busy %b want 0000/0", grant, busy); end
        checks++;
        if (s_tready !== 4'b0000 || fifo_w_en !== 1'b0) begin failures++; $display("[TB] FAIL arst_port: ready %b wen %b want 0000/0", s_tready, fifo_w_en); end
        checks++;
        if (pkt_cnt !== 16'd0) begin failures++; $display("[TB] FAIL arst_cnt: got %0d want 0", pkt_cnt); end
        checks++;
        @(negedge clk);
        arst = 1'b0;
        e = 8'($urandom);
        set_req(0, 1'b1, 1'b1, e);
        tick();
        #1;
        if (grant !== 4'b0001 || fifo_w_data !== {1'b1, e}) begin failures++; $display("[TB] FAIL arst_after: grant %b data %h want 0001/%h", grant, fifo_w_data, {1'b1, e}); end
        checks++;
        tick();
        s_tvalid = '0;
        s_tlast  = '0;
        tick();
    endtask

    task automatic test_wrap();
        int pulses = 0;
        do_reset();
        for (int p = 0; p < 17; p++) begin
            int r = int'($urandom_range(N-1, 0));
            set_req(r, 1'b1, 1'b1, 8'($urandom));
            #1;
            if (pkt_done4) pulses++;
            tick();
            #1;
            if (pkt_done4) pulses++;
            tick();
            set_req(r, 1'b0, 1'b0, 8'h00);
        end
        #1;
        if (pkt_done4) pulses++;
        if (pulses != 17) begin failures++; $display("[TB] FAIL wrap_pulses: got %0d want 17", pulses); end
        checks++;
        if (pkt_cnt4 !== 4'd1) begin failures++; $display("[TB] FAIL wrap_cnt4: got %0d want 1", pkt_cnt4); end
        checks++;
        if (pkt_cnt !== 16'd17) begin failures++; $display("[TB] FAIL wrap_cnt16: got %0d want 17", pkt_cnt); end
        checks++;
        tick();
    endtask

    task automatic test_random();
        int len [N];
        int pos [N];
        logic [7:0] cur [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            len[i] = int'($urandom_range(4, 1));
            pos[i] = 0;
            cur[i] = 8'($urandom);
        end
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] hs;
            if ($urandom_range(15, 0) == 0) req_en = N'($urandom);
            fifo_w_full = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < N; i++) set_req(i, $urandom_range(3, 0) != 0, pos[i] == len[i] - 1, cur[i]);
            #1;
            if (grant !== exp_grant() || busy !== (m_owner >= 0)) begin failures++; $display("[TB] FAIL rnd_grant c%0d: grant %b busy %b want %b", c, grant, busy, exp_grant()); end
            checks++;
            if (s_tready !== exp_ready()) begin failures++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, s_tready, exp_ready()); end
            checks++;
            if (fifo_w_en !== exp_wen()) begin failures++; $display("[TB] FAIL rnd_wen c%0d: got %b want %b", c, fifo_w_en, exp_wen()); end
            checks++;
            if (exp_wen()) begin
                if (fifo_w_data !== exp_wdata()) begin failures++; $display("[TB] FAIL rnd_data c%0d: got %h want %h", c, fifo_w_data, exp_wdata()); end
                checks++;
            end
            if (pkt_done !== m_done) begin failures++; $display("[TB] FAIL rnd_done c%0d: got %b want %b", c, pkt_done, m_done); end
            checks++;
            if (pkt_cnt !== 16'(m_cnt) || pkt_cnt4 !== 4'(m_cnt)) begin failures++; $display("[TB] FAIL rnd_cnt c%0d: got %0d/%0d want %0d", c, pkt_cnt, pkt_cnt4, m_cnt); end
            checks++;
            hs = exp_ready() & s_tvalid;
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    cur[i] = 8'($urandom);
                    pos[i]++;
                    if (pos[i] == len[i]) begin
                        pos[i] = 0;
                        len[i] = int'($urandom_range(4, 1));
                    end
                end
            end
        end
        s_tvalid    = '0;
        fifo_w_full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_mask();
        test_async_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
